// File: rtl/sfp_pkg.sv
// Shared types and constants for the softmax-row sequencer.
package sfp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ACC   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_DIV   = 3'd3,
      ST_FLUSH = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   localparam logic [1:0] SFP_NOP = 2'b00;
   localparam logic [1:0] SFP_ACC = 2'b01;
   localparam logic [1:0] SFP_DIV = 2'b10;

   localparam int unsigned DRAIN_LEN = 2;

endpackage

// File: rtl/sfp_seq_rx.sv
// Remote-sum puller: pops the partner core's sum FIFO at most every other cycle
// and counts the sums that have landed in the local FIFO.
module sfp_seq_rx #(
   parameter int NROW = 8,
   parameter int CW   = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr_i,
   input  logic          run_i,
   input  logic          ext_empty_i,
   output logic          ext_rd_o,
   output logic          wr_sum_o,
   output logic [CW-1:0] rx_cnt_o
);

   localparam logic [CW-1:0] NROW_C = CW'(NROW);

   logic          ext_rd_q;
   logic          wr_sum_q;
   logic [CW-1:0] pop_cnt_q;
   logic [CW-1:0] rx_cnt_q;
   logic          pop_d;

   // Pops are counted when issued so a sum still in flight cannot cause an extra pop.
   always_comb begin
      pop_d = 1'b0;
      if (!ext_empty_i && !ext_rd_q) begin
         if (clr_i) begin
            pop_d = 1'b1;
         end else if (run_i && (pop_cnt_q < NROW_C)) begin
            pop_d = 1'b1;
         end else begin
            pop_d = 1'b0;
         end
      end else begin
         pop_d = 1'b0;
      end
   end

   // Pop strobe, its one-cycle-late FIFO write, and the landed-sum count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ext_rd_q  <= 1'b0;
         wr_sum_q  <= 1'b0;
         pop_cnt_q <= {CW{1'b0}};
         rx_cnt_q  <= {CW{1'b0}};
      end else begin
         ext_rd_q <= pop_d;
         wr_sum_q <= ext_rd_q;
         if (clr_i) begin
            pop_cnt_q <= {{(CW-1){1'b0}}, pop_d};
            rx_cnt_q  <= {CW{1'b0}};
         end else begin
            pop_cnt_q <= pop_cnt_q + {{(CW-1){1'b0}}, pop_d};
            rx_cnt_q  <= rx_cnt_q + {{(CW-1){1'b0}}, wr_sum_q};
         end
      end
   end

   assign ext_rd_o = ext_rd_q;
   assign wr_sum_o = wr_sum_q;
   assign rx_cnt_o = rx_cnt_q;

endmodule

// File: rtl/sfp_seq.sv
// Sequencer for one sfp_row: accumulate pass, drain, divide pass gated by partner sums.
// Optional DIV-stall timeout is built when SFP_SEQ_TIMEOUT_EN is defined.
module sfp_seq
   import sfp_pkg::*;
#(
   parameter int NROW = 8,
   parameter int AW   = 4,
   parameter int TO_W = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] rd_base,
   input  logic [AW-1:0] wr_base,
   input  logic          ext_empty,
   output logic          ext_rd,
   output logic          wr_sum,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   output logic [1:0]    sfp_inst,
   output logic          out_wr,
   output logic [AW-1:0] out_addr,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int CW = AW + 1;
   localparam logic [CW-1:0] NROW_LAST = CW'(NROW - 1);
   localparam logic [1:0]    DRAIN_LAST = 2'(DRAIN_LEN - 1);

   state_e        state_q;
   logic [AW-1:0] rd_base_q, wr_base_q;
   logic [CW-1:0] rd_cnt_q;
   logic [AW-1:0] div_cnt_q;
   logic [1:0]    drain_q;
   logic          mem_rd_q, out_wr_q, busy_q, done_q;
   logic [AW-1:0] mem_addr_q, out_addr_q;
   logic [1:0]    rd_op_q, inst_q;
   logic [CW-1:0] rx_cnt;
   logic          start_ok_d, run_d, issue_d;
`ifdef SFP_SEQ_TIMEOUT_EN
   localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
   logic [TO_W-1:0] to_cnt_q;
   logic            err_q;
`endif

   // Row r of the divide pass needs the registered count of landed partner sums to exceed r.
   always_comb begin
      start_ok_d = (state_q == ST_IDLE) && start;
      run_d      = (state_q == ST_ACC) || (state_q == ST_DRAIN) || (state_q == ST_DIV);
      issue_d    = (state_q == ST_DIV) && (rx_cnt > rd_cnt_q);
   end

   sfp_seq_rx #(.NROW(NROW), .CW(CW)) u_rx (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (start_ok_d),
      .run_i      (run_d),
      .ext_empty_i(ext_empty),
      .ext_rd_o   (ext_rd),
      .wr_sum_o   (wr_sum),
      .rx_cnt_o   (rx_cnt)
   );

   // Tile FSM with its counters and every registered output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         rd_base_q  <= {AW{1'b0}};
         wr_base_q  <= {AW{1'b0}};
         rd_cnt_q   <= {CW{1'b0}};
         div_cnt_q  <= {AW{1'b0}};
         drain_q    <= 2'b00;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= {AW{1'b0}};
         rd_op_q    <= SFP_NOP;
         inst_q     <= SFP_NOP;
         out_wr_q   <= 1'b0;
         out_addr_q <= {AW{1'b0}};
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef SFP_SEQ_TIMEOUT_EN
         to_cnt_q   <= {TO_W{1'b0}};
         err_q      <= 1'b0;
`endif
      end else begin
         mem_rd_q <= 1'b0;
         done_q   <= 1'b0;
         inst_q   <= mem_rd_q ? rd_op_q : SFP_NOP;
         out_wr_q <= (inst_q == SFP_DIV);
         if (inst_q == SFP_DIV) begin
            out_addr_q <= wr_base_q + div_cnt_q;
            div_cnt_q  <= div_cnt_q + 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (start_ok_d) begin
                  rd_base_q  <= rd_base;
                  wr_base_q  <= wr_base;
                  div_cnt_q  <= {AW{1'b0}};
                  drain_q    <= 2'b00;
                  rd_cnt_q   <= {{(CW-1){1'b0}}, 1'b1};
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= rd_base;
                  rd_op_q    <= SFP_ACC;
                  busy_q     <= 1'b1;
                  state_q    <= (NROW_LAST == {CW{1'b0}}) ? ST_DRAIN : ST_ACC;
`ifdef SFP_SEQ_TIMEOUT_EN
                  to_cnt_q   <= {TO_W{1'b0}};
                  err_q      <= 1'b0;
`endif
               end
            end
            ST_ACC: begin
               mem_rd_q   <= 1'b1;
               mem_addr_q <= rd_base_q + rd_cnt_q[AW-1:0];
               rd_op_q    <= SFP_ACC;
               rd_cnt_q   <= rd_cnt_q + 1'b1;
               if (rd_cnt_q == NROW_LAST) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (drain_q == DRAIN_LAST) begin
                  rd_cnt_q <= {CW{1'b0}};
                  state_q  <= ST_DIV;
               end else begin
                  drain_q <= drain_q + 1'b1;
               end
            end
            ST_DIV: begin
               if (issue_d) begin
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= rd_base_q + rd_cnt_q[AW-1:0];
                  rd_op_q    <= SFP_DIV;
                  rd_cnt_q   <= rd_cnt_q + 1'b1;
`ifdef SFP_SEQ_TIMEOUT_EN
                  to_cnt_q   <= {TO_W{1'b0}};
`endif
                  if (rd_cnt_q == NROW_LAST) begin
                     state_q <= ST_FLUSH;
                  end
               end else begin
`ifdef SFP_SEQ_TIMEOUT_EN
                  // Give up on the remaining rows once the stall run hits the limit.
                  if (to_cnt_q == TO_LAST) begin
                     err_q   <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     to_cnt_q <= to_cnt_q + 1'b1;
                  end
`endif
               end
            end
            ST_FLUSH: begin
               // The last row's write is on the port once nothing remains upstream of it.
               if (!mem_rd_q && (inst_q == SFP_NOP)) begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_rd   = mem_rd_q;
   assign mem_addr = mem_addr_q;
   assign sfp_inst = inst_q;
   assign out_wr   = out_wr_q;
   assign out_addr = out_addr_q;
   assign busy     = busy_q;
   assign done     = done_q;
`ifdef SFP_SEQ_TIMEOUT_EN
   assign err      = err_q;
`else
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_sfp_seq.sv
// Scoreboard bench for sfp_seq: stimulus pushes hand-derived (cycle, value) events,
// a negedge monitor pops and compares them whenever the DUT shows an output event.
module tb_sfp_seq;

   localparam int NROW = 8;
   localparam int AW   = 4;
   localparam int AMOD = 16;
`ifdef SFP_SEQ_TIMEOUT_EN
   localparam int TB_TO_W = 4;
`else
   localparam int TB_TO_W = 8;
`endif

   typedef struct {int c; int v;} ev_t;

   logic          clk = 1'b0;
   logic          reset, start, ext_empty;
   logic [AW-1:0] rd_base, wr_base;
   logic          ext_rd, wr_sum, mem_rd, out_wr, busy, done, err;
   logic [AW-1:0] mem_addr, out_addr;
   logic [1:0]    sfp_inst;

   int  cyc = 0;
   int  t0 = 0;
   int  checks = 0;
   int  errors = 0;
   ev_t q_rd[$], q_in[$], q_wr[$], q_dn[$], q_ex[$], q_ws[$];

   sfp_seq #(.NROW(NROW), .AW(AW), .TO_W(TB_TO_W)) dut (
      .clk(clk), .reset(reset), .start(start), .rd_base(rd_base), .wr_base(wr_base),
      .ext_empty(ext_empty), .ext_rd(ext_rd), .wr_sum(wr_sum), .mem_rd(mem_rd),
      .mem_addr(mem_addr), .sfp_inst(sfp_inst), .out_wr(out_wr), .out_addr(out_addr),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d after start)", nm, act, exp, cyc - t0);
      end
   endtask

   task automatic unexp(input string nm, input int rel, input int v);
      checks++;
      errors++;
      $display("FAIL %s: unexpected event at cycle %0d value %0d, none required", nm, rel, v);
   endtask

   function automatic ev_t mk(input int c, input int v);
      ev_t e;
      e.c = c;
      e.v = v;
      return e;
   endfunction

   // Expected events of one tile; events at or after 'cut' are never observed.
   task automatic plan(input int rb, input int wb, input int ndiv, input int dfirst, input int dstep,
                       input int next, input int efirst, input int donec, input int cut);
      for (int r = 0; r < NROW; r++) begin
         if (1 + r < cut) q_rd.push_back(mk(1 + r, (rb + r) % AMOD));
         if (2 + r < cut) q_in.push_back(mk(2 + r, 1));
      end
      for (int r = 0; r < ndiv; r++) begin
         if (dfirst + r * dstep < cut)     q_rd.push_back(mk(dfirst + r * dstep, (rb + r) % AMOD));
         if (dfirst + 1 + r * dstep < cut) q_in.push_back(mk(dfirst + 1 + r * dstep, 2));
         if (dfirst + 2 + r * dstep < cut) q_wr.push_back(mk(dfirst + 2 + r * dstep, (wb + r) % AMOD));
      end
      for (int k = 0; k < next; k++) begin
         if (efirst + 2 * k < cut)     q_ex.push_back(mk(efirst + 2 * k, 1));
         if (efirst + 1 + 2 * k < cut) q_ws.push_back(mk(efirst + 1 + 2 * k, 1));
      end
      if (donec >= 0 && donec < cut) q_dn.push_back(mk(donec, 1));
   endtask

   task automatic start_tile(input int rb, input int wb);
      @(posedge clk); #1;
      rd_base = AW'(rb);
      wr_base = AW'(wb);
      start   = 1'b1;
      t0      = cyc;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   task automatic wait_rel(input int target);
      while (cyc - t0 < target) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic drain_check();
      cmp("rd_left", q_rd.size(), 0);
      cmp("inst_left", q_in.size(), 0);
      cmp("wr_left", q_wr.size(), 0);
      cmp("done_left", q_dn.size(), 0);
      cmp("ext_rd_left", q_ex.size(), 0);
      cmp("wr_sum_left", q_ws.size(), 0);
   endtask

   // Monitor: every output event must match the next expected one of its kind.
   always @(negedge clk) begin : mon
      int  rel;
      ev_t e;
      rel = cyc - t0;
      if (mem_rd) begin
         if (q_rd.size() == 0) unexp("mem_rd", rel, int'(mem_addr));
         else begin
            e = q_rd.pop_front();
            cmp("rd_cycle", rel, e.c);
            cmp("rd_addr", int'(mem_addr), e.v);
         end
      end
      if (sfp_inst != 2'b00) begin
         if (q_in.size() == 0) unexp("sfp_inst", rel, int'(sfp_inst));
         else begin
            e = q_in.pop_front();
            cmp("inst_cycle", rel, e.c);
            cmp("inst_op", int'(sfp_inst), e.v);
         end
      end
      if (out_wr) begin
         if (q_wr.size() == 0) unexp("out_wr", rel, int'(out_addr));
         else begin
            e = q_wr.pop_front();
            cmp("wr_cycle", rel, e.c);
            cmp("wr_addr", int'(out_addr), e.v);
         end
      end
      if (done) begin
         if (q_dn.size() == 0) unexp("done", rel, 1);
         else begin
            e = q_dn.pop_front();
            cmp("done_cycle", rel, e.c);
         end
      end
      if (ext_rd) begin
         if (q_ex.size() == 0) unexp("ext_rd", rel, 1);
         else begin
            e = q_ex.pop_front();
            cmp("ext_rd_cycle", rel, e.c);
         end
      end
      if (wr_sum) begin
         if (q_ws.size() == 0) unexp("wr_sum", rel, 1);
         else begin
            e = q_ws.pop_front();
            cmp("wr_sum_cycle", rel, e.c);
         end
      end
   end

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      rd_base   = 4'd0;
      wr_base   = 4'd0;
      ext_empty = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cmp("rst_mem_rd", int'(mem_rd), 0);
      cmp("rst_inst", int'(sfp_inst), 0);
      cmp("rst_out_wr", int'(out_wr), 0);
      cmp("rst_busy", int'(busy), 0);
      cmp("rst_done", int'(done), 0);
      cmp("rst_err", int'(err), 0);
      cmp("rst_ext_rd", int'(ext_rd), 0);
      reset = 1'b0;
      repeat (2) @(posedge clk);

      // Unstalled tile, bases 0/0.
      plan(0, 0, NROW, 11, 1, NROW, 1, 21, 1000);
      start_tile(0, 0);
      cmp("busy_run", int'(busy), 1);
      wait_rel(21);
      cmp("busy_done", int'(busy), 1);
      wait_rel(24);
      cmp("busy_idle", int'(busy), 0);
      drain_check();

      // Address wrap on both passes.
      plan(14, 13, NROW, 11, 1, NROW, 1, 21, 1000);
      start_tile(14, 13);
      wait_rel(24);
      drain_check();

      // Start pulse during ACC must be ignored.
      plan(2, 5, NROW, 11, 1, NROW, 1, 21, 1000);
      start_tile(2, 5);
      wait_rel(4);
      start   = 1'b1;
      rd_base = 4'd9;
      wr_base = 4'd9;
      @(posedge clk); #1;
      start   = 1'b0;
      wait_rel(24);
      drain_check();

`ifndef SFP_SEQ_TIMEOUT_EN
      // Partner FIFO empty for 30 cycles: DIV stalls, then one row per two cycles.
      ext_empty = 1'b1;
      plan(5, 2, NROW, 34, 2, NROW, 31, 51, 1000);
      start_tile(5, 2);
      wait_rel(30);
      ext_empty = 1'b0;
      wait_rel(54);
      cmp("err_tied", int'(err), 0);
      drain_check();
`else
      // Stuck-empty partner FIFO: timeout after 15 DIV stall cycles.
      ext_empty = 1'b1;
      plan(0, 0, 0, 0, 1, 0, 0, 25, 1000);
      start_tile(0, 0);
      wait_rel(24);
      cmp("err_before", int'(err), 0);
      wait_rel(25);
      cmp("err_set", int'(err), 1);
      wait_rel(28);
      cmp("err_sticky", int'(err), 1);
      cmp("busy_after_to", int'(busy), 0);
      drain_check();
      ext_empty = 1'b0;
      plan(1, 1, NROW, 11, 1, NROW, 1, 21, 1000);
      start_tile(1, 1);
      cmp("err_cleared", int'(err), 0);
      wait_rel(24);
      drain_check();
`endif

      // Asynchronous reset while row 3 of the divide pass is launched.
      plan(3, 7, NROW, 11, 1, NROW, 1, 21, 14);
      start_tile(3, 7);
      wait_rel(14);
      reset = 1'b1;
      #1;
      cmp("ar_mem_rd", int'(mem_rd), 0);
      cmp("ar_inst", int'(sfp_inst), 0);
      cmp("ar_out_wr", int'(out_wr), 0);
      cmp("ar_wr_sum", int'(wr_sum), 0);
      cmp("ar_busy", int'(busy), 0);
      cmp("ar_mem_addr", int'(mem_addr), 0);
      cmp("ar_out_addr", int'(out_addr), 0);
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      cmp("ar_idle_busy", int'(busy), 0);
      drain_check();

      // A fresh tile after the abort runs completely.
      plan(3, 7, NROW, 11, 1, NROW, 1, 21, 1000);
      start_tile(3, 7);
      wait_rel(24);
      drain_check();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
